// File: rtl/jtag_userop_sched.sv
// Purpose: small first-word-fall-through queue holding {opcode, operand} commands from the TAP.
// Latency: a pushed entry is visible on rdat one cycle later; a pop frees the slot the same edge.
// Backpressure: none internally; the caller only pushes when there is room or a pop happens in the same cycle.
module jtag_userop_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdat,
  output logic [W-1:0]                 rdat,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  assign rdat  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdat;
  end
endmodule

// Purpose: queues TAP user ops and executes them in order on a valid/ready bus master, reporting data/status back.
// Latency: op pushed at E0 is popped at E1; bus_valid rises after E1; READ data lands after the bus_ready edge.
// Backpressure: bus_ready stalls the FSM (bounded by TIMEOUT); pushes into a full, non-popping queue are dropped.
module jtag_userop_sched #(
  parameter int USERDATA_LEN = 32,
  parameter int USEROP_LEN   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 255,
  parameter int ADDR_INC     = 4
) (
  input  logic                    tck,
  input  logic                    trst,
  input  logic [USEROP_LEN-1:0]   userOp,
  input  logic                    userOp_ready,
  input  logic [USERDATA_LEN-1:0] userData_out,
  output logic [USERDATA_LEN-1:0] userData_in,
  output logic                    bus_valid,
  output logic                    bus_we,
  output logic [USERDATA_LEN-1:0] bus_addr,
  output logic [USERDATA_LEN-1:0] bus_wdata,
  input  logic [USERDATA_LEN-1:0] bus_rdata,
  input  logic                    bus_ready,
  output logic                    busy,
  output logic                    err
);
  localparam int EW = USEROP_LEN + USERDATA_LEN;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [USEROP_LEN-1:0] OP_SET  = USEROP_LEN'(1);
  localparam logic [USEROP_LEN-1:0] OP_WR   = USEROP_LEN'(2);
  localparam logic [USEROP_LEN-1:0] OP_RD   = USEROP_LEN'(3);
  localparam logic [USEROP_LEN-1:0] OP_STAT = USEROP_LEN'(4);
  localparam logic [USEROP_LEN-1:0] OP_CLR  = USEROP_LEN'(5);

  typedef enum logic {IDLE, BUS} state_t;

  state_t                  state;
  logic [USERDATA_LEN-1:0] addr;
  logic [TW-1:0]           tcnt;
  logic                    ovf, ill, tmo;

  logic [EW-1:0]           head;
  logic [CW-1:0]           count;
  logic                    full, empty;
  logic                    pop, push_ok;
  logic [USEROP_LEN-1:0]   head_op;
  logic [USERDATA_LEN-1:0] head_dat;

  assign head_op  = head[EW-1 -: USEROP_LEN];
  assign head_dat = head[USERDATA_LEN-1:0];
  assign pop      = (state == IDLE) && !empty;
  assign push_ok  = userOp_ready && (!full || pop);
  assign busy     = !empty || (state != IDLE);

  jtag_userop_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (tck),
    .rst   (trst),
    .push  (push_ok),
    .pop   (pop),
    .wdat  ({userOp, userData_out}),
    .rdat  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  logic                    clr, to_fire;
  logic                    ovf_n, ill_n, tmo_n;
  logic [CW-1:0]           cnt_nxt;
  logic [USERDATA_LEN-1:0] status;

  // Sticky flags: a set arriving in the same cycle as CLEAR_ERR wins.
  always_comb begin
    clr     = pop && (head_op == OP_CLR);
    to_fire = (state == BUS) && !bus_ready && (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    ovf_n   = (ovf && !clr) || (userOp_ready && full && !pop);
    ill_n   = (ill && !clr) || (pop && (head_op > OP_CLR));
    tmo_n   = (tmo && !clr) || to_fire;
    cnt_nxt = count + CW'(push_ok) - CW'(pop);
    // Status reflects the queue as it stands after this STATUS entry leaves it.
    status      = '0;
    status[0]   = (cnt_nxt != '0);
    status[1]   = ovf_n;
    status[2]   = ill_n;
    status[3]   = tmo_n;
    status[7:4] = 4'(cnt_nxt);
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state       <= IDLE;
      addr        <= '0;
      tcnt        <= '0;
      ovf         <= 1'b0;
      ill         <= 1'b0;
      tmo         <= 1'b0;
      err         <= 1'b0;
      userData_in <= '0;
      bus_valid   <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
    end else begin
      ovf <= ovf_n;
      ill <= ill_n;
      tmo <= tmo_n;
      err <= ovf_n || ill_n || tmo_n;
      case (state)
        IDLE: begin
          if (pop) begin
            case (head_op)
              OP_SET:  addr <= head_dat;
              OP_STAT: userData_in <= status;
              OP_WR, OP_RD: begin
                state     <= BUS;
                bus_valid <= 1'b1;
                bus_we    <= (head_op == OP_WR);
                bus_addr  <= addr;
                if (head_op == OP_WR) bus_wdata <= head_dat;
                tcnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        BUS: begin
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state     <= IDLE;
            addr      <= addr + USERDATA_LEN'(ADDR_INC);
            if (!bus_we) userData_in <= bus_rdata;
          end else if (to_fire) begin
            bus_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_userop_sched.sv
// Directed bench for jtag_userop_sched: bus completions are checked by a queue-driven monitor,
// TAP-visible results (userData_in, err, busy) by directed checks once the sequencer is idle.
module tb_jtag_userop_sched;
  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic [7:0]  userOp = '0;
  logic        userOp_ready = 1'b0;
  logic [31:0] userData_out = '0;
  logic [31:0] userData_in;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        busy, err;

  int   checks = 0;
  int   errors = 0;
  logic stall = 1'b0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] mem [logic [31:0]];

  jtag_userop_sched #(
    .USERDATA_LEN(32), .USEROP_LEN(8), .FIFO_DEPTH(4), .TIMEOUT(8), .ADDR_INC(4)
  ) dut (
    .tck          (tck),
    .trst         (trst),
    .userOp       (userOp),
    .userOp_ready (userOp_ready),
    .userData_out (userData_out),
    .userData_in  (userData_in),
    .bus_valid    (bus_valid),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ready    (bus_ready),
    .busy         (busy),
    .err          (err)
  );

  always #5 tck = ~tck;

  // Bus slave: answers one cycle after bus_valid unless stalled; backs a sparse memory.
  initial begin
    forever begin
      @(negedge tck);
      #1;
      if (bus_valid && !stall && !trst) begin
        bus_ready = 1'b1;
        if (bus_we) mem[bus_addr] = bus_wdata;
        else bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
      end else begin
        bus_ready = 1'b0;
      end
    end
  end

  initial begin : monitor
    txn_t t;
    forever begin
      @(negedge tck);
      #2;
      if (bus_valid && bus_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected got we=%b addr=%h wdata=%h want no transfer", bus_we, bus_addr, bus_wdata);
        end else begin
          t = exp_q.pop_front();
          if (bus_we !== t.we || bus_addr !== t.addr || (t.we && bus_wdata !== t.dat)) begin
            errors++;
            $display("FAIL bus_txn got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     bus_we, bus_addr, bus_wdata, t.we, t.addr, t.dat);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Caller is at a negedge; the op is sampled at the next posedge.
  task automatic send(input logic [7:0] op, input logic [31:0] d);
    userOp       = op;
    userData_out = d;
    userOp_ready = 1'b1;
    @(negedge tck);
    userOp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge tck);
    while (busy && n < 200) begin
      @(negedge tck);
      n++;
    end
    chk("wait_idle_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic exp_txn(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we   = we;
    t.addr = a;
    t.dat  = d;
    exp_q.push_back(t);
  endtask

  initial begin : stim
    int vcnt;
    int extra;

    // Reset then idle
    repeat (3) @(negedge tck);
    trst = 1'b0;
    chk("rst_bus_valid",   {31'b0, bus_valid}, 32'h0);
    chk("rst_bus_we",      {31'b0, bus_we},    32'h0);
    chk("rst_bus_addr",    bus_addr,           32'h0);
    chk("rst_bus_wdata",   bus_wdata,          32'h0);
    chk("rst_userdata_in", userData_in,        32'h0);
    chk("rst_busy",        {31'b0, busy},      32'h0);
    chk("rst_err",         {31'b0, err},       32'h0);
    repeat (20) @(negedge tck);
    send(8'h04, 32'h0);
    wait_idle();
    chk("idle_status", userData_in, 32'h0000_0000);

    // Write then read back at the same address
    exp_txn(1'b1, 32'h100, 32'hDEAD_BEEF);
    exp_txn(1'b0, 32'h100, 32'h0);
    send(8'h01, 32'h100);
    send(8'h02, 32'hDEAD_BEEF);
    send(8'h01, 32'h100);
    send(8'h03, 32'h0);
    wait_idle();
    chk("wr_rd_data", userData_in, 32'hDEAD_BEEF);
    send(8'h04, 32'h0);
    wait_idle();
    chk("wr_rd_status", userData_in, 32'h0000_0000);

    // Overflow: one in BUS, four queued, sixth dropped
    send(8'h01, 32'h200);
    wait_idle();
    stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_txn(1'b1, 32'h200 + 32'(4 * (i - 1)), 32'(i) * 32'h1111_1111);
      send(8'h02, 32'(i) * 32'h1111_1111);
    end
    chk("ovf_err", {31'b0, err}, 32'h1);
    chk("ovf_busy", {31'b0, busy}, 32'h1);
    stall = 1'b0;
    wait_idle();
    send(8'h04, 32'h0);
    wait_idle();
    chk("ovf_status", userData_in, 32'h0000_0002);
    send(8'h05, 32'h0);
    wait_idle();
    chk("ovf_clear_err", {31'b0, err}, 32'h0);

    // Timeout on a READ, data unchanged, address not advanced
    exp_txn(1'b0, 32'h200, 32'h0);
    send(8'h01, 32'h200);
    send(8'h03, 32'h0);
    wait_idle();
    chk("rd_prior", userData_in, 32'h1111_1111);
    stall = 1'b1;
    send(8'h03, 32'h0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (bus_valid) vcnt++;
      else if (vcnt > 0) break;
      @(negedge tck);
    end
    chk("to_valid_cycles", 32'(vcnt), 32'd8);
    chk("to_keep_data", userData_in, 32'h1111_1111);
    stall = 1'b0;
    @(negedge tck);
    send(8'h04, 32'h0);
    wait_idle();
    chk("to_status", userData_in, 32'h0000_0008);
    chk("to_err", {31'b0, err}, 32'h1);
    send(8'h05, 32'h0);
    send(8'h04, 32'h0);
    wait_idle();
    chk("clr_then_status", userData_in, 32'h0000_0000);
    chk("clr_err", {31'b0, err}, 32'h0);
    exp_txn(1'b0, 32'h204, 32'h0);
    send(8'h03, 32'h0);
    wait_idle();
    chk("to_no_addr_inc", userData_in, 32'h2222_2222);

    // Illegal opcode and address wrap-around
    exp_txn(1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5);
    exp_txn(1'b1, 32'h0000_0000, 32'h5A5A_5A5A);
    send(8'h7F, 32'h0);
    send(8'h01, 32'hFFFF_FFFC);
    send(8'h02, 32'hA5A5_A5A5);
    send(8'h02, 32'h5A5A_5A5A);
    wait_idle();
    chk("ill_err", {31'b0, err}, 32'h1);
    send(8'h04, 32'h0);
    wait_idle();
    chk("ill_status", userData_in, 32'h0000_0004);
    send(8'h05, 32'h0);
    wait_idle();

    // Reset while in BUS with three entries queued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h02, 32'hC0DE_0000 + 32'(i));
    #2;
    chk("pre_rst_valid", {31'b0, bus_valid}, 32'h1);
    trst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, bus_valid}, 32'h0);
    chk("rst_fifo_empty", {31'b0, busy}, 32'h0);
    @(negedge tck);
    trst  = 1'b0;
    stall = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge tck);
      if (bus_valid) extra++;
    end
    chk("no_req_after_rst", 32'(extra), 32'h0);
    send(8'h04, 32'h0);
    wait_idle();
    chk("post_rst_status", userData_in, 32'h0000_0000);

    repeat (3) @(negedge tck);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_userop_sched.md
# jtag_userop_sched

Command sequencer that sits behind the JTAG TAP's user-data/user-op interface, on the same `tck` clock domain. It queues user operations delivered by the TAP (address set, write, read, status) in a small FIFO and executes them in order against a simple valid/ready memory-mapped bus master port. It returns read data and status to the TAP's capture register, with sticky error reporting and a bus timeout.

## Interface
- `USERDATA_LEN`, 32: width of TAP user data, bus address and bus data.
- `USEROP_LEN`, 8: width of TAP user opcode.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, 2..15.
- `TIMEOUT`, 255: max cycles `bus_valid` waits for `bus_ready`; 0 disables the timeout.
- `ADDR_INC`, 4: post-increment applied to the address after each WRITE/READ.

Ports:
- `tck` in 1: clock; all state on rising edge.
- `trst` in 1: asynchronous, active-high reset.
- `userOp` in USEROP_LEN: opcode from TAP, valid with `userOp_ready`.
- `userOp_ready` in 1: one-cycle strobe; the TAP has completed an op/data update.
- `userData_out` in USERDATA_LEN: operand from TAP, valid with `userOp_ready`.
- `userData_in` out USERDATA_LEN: value the TAP captures on the next capture-DR.
- `bus_valid` out 1: bus request.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out USERDATA_LEN: request address.
- `bus_wdata` out USERDATA_LEN: write data.
- `bus_rdata` in USERDATA_LEN: read data, sampled when `bus_ready`=1.
- `bus_ready` in 1: completes the request.
- `busy` out 1: FIFO non-empty or FSM not IDLE.
- `err` out 1: OR of the sticky error flags.

## Operation
- Opcodes: 0x00 NOP, 0x01 SET_ADDR (addr ← operand), 0x02 WRITE (bus write of operand at addr, then addr += ADDR_INC), 0x03 READ (bus read at addr, then `userData_in` ← rdata and addr += ADDR_INC), 0x04 STATUS (`userData_in` ← status word), 0x05 CLEAR_ERR (clears sticky flags). Any other opcode sets sticky ILLEGAL and is otherwise ignored.
- Status word: bit0 `busy`, bit1 OVERFLOW, bit2 ILLEGAL, bit3 TIMEOUT, bits[7:4] FIFO count, remaining bits 0.
- FIFO entry = {opcode, operand}. Push on `userOp_ready`.
  - A push while full with no pop in the same cycle is dropped and sets OVERFLOW.
  - A push while full with a pop in the same cycle is accepted.
- FSM states:
  - IDLE: if FIFO non-empty, pop one entry. NOP, SET_ADDR, STATUS, CLEAR_ERR and illegal opcodes complete in the pop cycle; stay in IDLE. WRITE/READ go to BUS.
  - BUS: `bus_valid`=1 with `bus_addr`/`bus_we`/`bus_wdata` held stable. On `bus_ready`=1, complete and return to IDLE. If the wait counter reaches TIMEOUT first, drop the request, set TIMEOUT, do not increment addr, leave `userData_in` unchanged, and return to IDLE.
- Address arithmetic is modulo 2^USERDATA_LEN; wrap-around is silent.
- On a timeout, a READ leaves `userData_in` unchanged.
- CLEAR_ERR then STATUS, queued back to back, reports all flags 0, because ops execute strictly in order.
- A flag event coinciding with CLEAR_ERR execution: the set wins.

## Timing
- Reset values:
  - `bus_valid`, `bus_we`, `busy`, `err` = 0.
  - `bus_addr`, `bus_wdata`, `userData_in`, internal addr = 0.
  - FIFO empty; FSM IDLE; flags 0; timeout counter 0.
- `trst` mid-transaction drops `bus_valid` immediately (asynchronous) and discards the FIFO contents.
- Latency, with `userOp_ready` sampled at edge E0:
  - Entry becomes visible at E1 and is popped at E1.
  - `bus_valid` rises after E1.
  - With `bus_ready` high at E2, `bus_valid` falls after E2 and READ data appears on `userData_in` after E2.
  - Single-cycle ops update state after E1.
- Back-to-back WRITEs with `bus_ready` tied high: one bus transfer every 2 cycles. `bus_valid` deasserts for at least one cycle between requests.
- Timeout counter starts at 0 on entry to BUS and increments each cycle `bus_ready`=0. The timeout fires at the edge where the count equals TIMEOUT−1, giving TIMEOUT cycles of `bus_valid`.
- `userData_in` changes only on READ completion or STATUS execution.

## Test plan
- Reset then idle:
  - Stimulus: `trst` pulse, then 20 idle cycles.
  - Response: all outputs 0; STATUS returns 0x00000000.
- Write/read sequence:
  - Stimulus: SET_ADDR 0x100, WRITE 0xDEADBEEF, SET_ADDR 0x100, READ; bus model returns the stored value.
  - Response: write at 0x100; read at 0x100; `userData_in`=0xDEADBEEF; next STATUS shows addr-independent flags 0.
- Overflow:
  - Stimulus: hold `bus_ready`=0 and issue 6 WRITEs with FIFO_DEPTH=4.
  - Response: first WRITE in BUS; 4 queued; 1 dropped; OVERFLOW set; `err`=1.
- Timeout:
  - Stimulus: TIMEOUT=8, READ with `bus_ready` never asserted.
  - Response: `bus_valid` high exactly 8 cycles; STATUS = 0x00000008 (TIMEOUT bit); `userData_in` keeps its prior value; then CLEAR_ERR + STATUS gives 0x00000000.
- Illegal opcode and address wrap:
  - Stimulus: opcode 0x7F, then SET_ADDR 0xFFFFFFFC, WRITE, WRITE.
  - Response: ILLEGAL set; writes at 0xFFFFFFFC then 0x00000000.
- Reset mid-operation:
  - Stimulus: assert `trst` while in BUS with 3 entries queued.
  - Response: `bus_valid` falls without a clock edge; FIFO empty; no further bus requests after release.
